// File: rtl/i2s_pkg.sv
// Shared types for the i2s_txn audio transmitter: serial mode, frame state
// and the bit-counter width helper.
package i2s_pkg;

  typedef enum logic {
    MODE_I2S = 1'b0,
    MODE_LJ  = 1'b1
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Width of a counter spanning one LR period (0 .. 2*data_w-1)
  function automatic int unsigned bcnt_w(input int unsigned data_w);
    return $clog2(2 * data_w);
  endfunction

endpackage

// File: rtl/i2s_lane.sv
// One stereo data lane: left/right shift registers, copy of the last frame
// for underrun replay, and the one-sck delay flop that turns the
// left-justified stream into I2S. LJ selection exists only with I2S_LJ_EN.
module i2s_lane
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              fall,
  input  logic              frame_start,
  input  logic              reload,
`ifdef I2S_LJ_EN
  input  logic              lj_mode,
`endif
  input  logic [DATA_W-1:0] hold_l,
  input  logic [DATA_W-1:0] hold_r,
  output logic              d
);

  logic [DATA_W-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
  logic [DATA_W-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
  logic              dly_q, dly_d, d_q, d_d;
  logic              lj_bit;

  // Load or shift once per sck falling toggle; the MSB of sh_l is the LJ bit
  always_comb begin
    sh_l_d   = sh_l_q;
    sh_r_d   = sh_r_q;
    last_l_d = last_l_q;
    last_r_d = last_r_q;
    dly_d    = dly_q;
    d_d      = d_q;
    lj_bit   = 1'b0;
    if (fall) begin
      if (frame_start) begin
        sh_l_d   = reload ? last_l_q : hold_l;
        sh_r_d   = reload ? last_r_q : hold_r;
        last_l_d = sh_l_d;
        last_r_d = sh_r_d;
      end else begin
        {sh_l_d, sh_r_d} = {sh_l_q[DATA_W-2:0], sh_r_q, 1'b0};
      end
      lj_bit = sh_l_d[DATA_W-1];
      dly_d  = lj_bit;
`ifdef I2S_LJ_EN
      d_d    = lj_mode ? lj_bit : dly_q;
`else
      d_d    = dly_q;
`endif
    end
  end

  // Lane state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sh_l_q   <= '0;
      sh_r_q   <= '0;
      last_l_q <= '0;
      last_r_q <= '0;
      dly_q    <= 1'b0;
      d_q      <= 1'b0;
    end else begin
      sh_l_q   <= sh_l_d;
      sh_r_q   <= sh_r_d;
      last_l_q <= last_l_d;
      last_r_q <= last_r_d;
      dly_q    <= dly_d;
      d_q      <= d_d;
    end
  end

  assign d = d_q;

endmodule

// File: rtl/i2s_txn.sv
// Multi-lane I2S / left-justified transmitter top: clock dividers, frame
// bit counter, one-deep holding register with valid/ready, underrun pulse.
// Build option I2S_LJ_EN: when defined, lj picks I2S or LJ at each frame
// start; otherwise the mode is fixed at I2S.
module i2s_txn
  import i2s_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned LANES    = 1,
  parameter int unsigned SCK_HALF = 16,
  parameter int unsigned MCK_HALF = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    lj,
  input  logic                    sVal,
  output logic                    sRdy,
  input  logic [LANES*DATA_W-1:0] ldata,
  input  logic [LANES*DATA_W-1:0] rdata,
  output logic                    mck,
  output logic                    sck,
  output logic                    lr,
  output logic [LANES-1:0]        d,
  output logic                    urun
);

  localparam int unsigned BW  = bcnt_w(DATA_W);
  localparam int unsigned SCW = $clog2(SCK_HALF);
  localparam int unsigned MCW = (MCK_HALF > 1) ? $clog2(MCK_HALF) : 1;

  logic [SCW-1:0] sck_cnt_q, sck_cnt_d;
  logic [MCW-1:0] mck_cnt_q, mck_cnt_d;
  logic           sck_q, sck_d, mck_q, mck_d, sck_tick, mck_tick, fall;
  state_e         state_q, state_d;
  logic [BW-1:0]  b_q, b_d;
  logic           lr_q, lr_d, frame_start;
  logic [LANES*DATA_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
  logic           full_q, full_d, srdy_q, srdy_d, urun_q, urun_d;
  logic           accept, reload, lj_now;

  // Free-running sck and mck dividers
  always_comb begin
    sck_tick  = (sck_cnt_q == SCW'(SCK_HALF - 1));
    mck_tick  = (mck_cnt_q == MCW'(MCK_HALF - 1));
    sck_cnt_d = sck_tick ? '0 : sck_cnt_q + SCW'(1);
    mck_cnt_d = mck_tick ? '0 : mck_cnt_q + MCW'(1);
    sck_d     = sck_q ^ sck_tick;
    mck_d     = mck_q ^ mck_tick;
    fall      = sck_tick & sck_q;
  end

  // Divider registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sck_cnt_q <= '0;
      mck_cnt_q <= '0;
      sck_q     <= 1'b0;
      mck_q     <= 1'b0;
    end else begin
      sck_cnt_q <= sck_cnt_d;
      mck_cnt_q <= mck_cnt_d;
      sck_q     <= sck_d;
      mck_q     <= mck_d;
    end
  end

  // Frame FSM: bit counter, frame start and word clock
  always_comb begin
    state_d     = state_q;
    b_d         = b_q;
    lr_d        = lr_q;
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d     = ST_RUN;
          b_d         = '0;
          frame_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (fall) begin
          if (b_q == BW'(2 * DATA_W - 1)) begin
            b_d         = '0;
            frame_start = 1'b1;
          end else begin
            b_d = b_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (fall) lr_d = (b_d >= BW'(DATA_W));
  end

  // Frame FSM registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      lr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      lr_q    <= lr_d;
    end
  end

  // Holding register: transfer uses the pre-accept content, so an accept in
  // a frame-start clock with an empty holding is an underrun for that frame
  always_comb begin
    accept   = sVal & srdy_q;
    hold_l_d = hold_l_q;
    hold_r_d = hold_r_q;
    full_d   = full_q;
    urun_d   = 1'b0;
    if (frame_start) begin
      if (full_q) full_d = 1'b0;
      else        urun_d = 1'b1;
    end
    if (accept) begin
      hold_l_d = ldata;
      hold_r_d = rdata;
      full_d   = 1'b1;
    end
    srdy_d = ~full_d;
  end

  // Holding and handshake registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hold_l_q <= '0;
      hold_r_q <= '0;
      full_q   <= 1'b0;
      srdy_q   <= 1'b1;
      urun_q   <= 1'b0;
    end else begin
      hold_l_q <= hold_l_d;
      hold_r_q <= hold_r_d;
      full_q   <= full_d;
      srdy_q   <= srdy_d;
      urun_q   <= urun_d;
    end
  end

  assign reload = ~full_q;

`ifdef I2S_LJ_EN
  mode_e mode_q, mode_d;

  // Mode is sampled at frame start and applies from that clock on
  always_comb begin
    mode_d = mode_q;
    if (frame_start) mode_d = lj ? MODE_LJ : MODE_I2S;
    lj_now = (mode_d == MODE_LJ);
  end

  // Mode register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mode_q <= MODE_I2S;
    else        mode_q <= mode_d;
  end
`else
  logic unused_lj;
  assign unused_lj = lj;
  assign lj_now    = 1'b0;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    i2s_lane #(.DATA_W(DATA_W)) u_lane (
      .clock       (clock),
      .reset       (reset),
      .fall        (fall),
      .frame_start (frame_start),
      .reload      (reload),
`ifdef I2S_LJ_EN
      .lj_mode     (lj_now),
`endif
      .hold_l      (hold_l_q[k*DATA_W +: DATA_W]),
      .hold_r      (hold_r_q[k*DATA_W +: DATA_W]),
      .d           (d[k])
    );
  end

`ifndef I2S_LJ_EN
  logic unused_lj_now;
  assign unused_lj_now = lj_now;
`endif

  assign sck  = sck_q;
  assign mck  = mck_q;
  assign lr   = lr_q;
  assign sRdy = srdy_q;
  assign urun = urun_q;

endmodule

// File: tb/tb_i2s_txn.sv
// Self-checking bench for i2s_txn: an arithmetic model predicts every output
// from the number of clocks since reset release and the accepted samples.
`timescale 1ns/1ps
module tb_i2s_txn;
  localparam int unsigned DW    = 16;
  localparam int unsigned LN    = 2;
  localparam int unsigned SH    = 4;
  localparam int unsigned MH    = 2;
  localparam int unsigned FB    = 2 * DW;
  localparam int unsigned FRAME = 2 * SH * FB;
  localparam int unsigned NF    = 64;

  logic clock = 1'b0, rst_n = 1'b0, lj = 1'b0, sval = 1'b0;
  logic srdy, mck, sck, lr, urun;
  logic [LN-1:0]    d;
  logic [LN*DW-1:0] ldata = '0, rdata = '0;

  i2s_txn #(.DATA_W(DW), .LANES(LN), .SCK_HALF(SH), .MCK_HALF(MH)) dut (
    .clock(clock), .reset(rst_n), .lj(lj), .sVal(sval), .sRdy(srdy),
    .ldata(ldata), .rdata(rdata), .mck(mck), .sck(sck), .lr(lr),
    .d(d), .urun(urun)
  );

  always #5 clock = ~clock;

  int passed = 0, total = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  int n;                                  // clock edges since reset release
  bit m_full, m_urun;
  logic [DW-1:0] m_hl [LN], m_hr [LN];
  logic [FB-1:0] m_last [LN];
  logic [FB-1:0] fr_word [NF][LN];        // frame contents as {L,R}
  bit            fr_lj [NF];
  bit  m_fs, m_acc;
  int  m_f, m_fr;

  always @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      n = 0; m_full = 0; m_urun = 0;
      for (int k = 0; k < LN; k++) begin
        m_last[k] = '0; m_hl[k] = '0; m_hr[k] = '0;
      end
    end else begin
      n++;
      m_f   = n / (2 * SH);
      m_fs  = (n % (2 * SH) == 0) && ((m_f - 1) % FB == 0);
      m_acc = sval && !m_full;
      m_urun = 0;
      if (m_fs) begin
        m_fr = (m_f - 1) / FB;
        for (int k = 0; k < LN; k++) begin
          fr_word[m_fr % NF][k] = m_full ? {m_hl[k], m_hr[k]} : m_last[k];
          m_last[k] = fr_word[m_fr % NF][k];
        end
`ifdef I2S_LJ_EN
        fr_lj[m_fr % NF] = lj;
`else
        fr_lj[m_fr % NF] = 1'b0;
`endif
        m_urun = !m_full;
        m_full = 0;
      end
      if (m_acc) begin
        for (int k = 0; k < LN; k++) begin
          m_hl[k] = ldata[k*DW +: DW];
          m_hr[k] = rdata[k*DW +: DW];
        end
        m_full = 1;
      end
    end
  end

  // Left-justified bit of lane k during sck period p (period 0 = first frame start)
  function automatic logic lj_bit(input int p, input int k);
    logic [FB-1:0] w;
    w = fr_word[(p / FB) % NF][k];
    return w[FB - 1 - (p % FB)];
  endfunction

  // ---------------- per-cycle compare ----------------
  int c_f, c_p;
  logic [LN-1:0] c_d;
  logic c_lr;
  always @(negedge clock) begin
    if (rst_n && cmp_en) begin
      c_f = n / (2 * SH);
      c_d = '0;
      c_lr = 1'b1;
      if (c_f > 0) begin
        c_p  = c_f - 1;
        c_lr = ((c_p % FB) >= DW);
        for (int k = 0; k < LN; k++) begin
          if (fr_lj[(c_p / FB) % NF]) c_d[k] = lj_bit(c_p, k);
          else                         c_d[k] = (c_p >= 1) ? lj_bit(c_p - 1, k) : 1'b0;
        end
      end
      check("sck",  64'(sck),  64'((n / SH) % 2));
      check("mck",  64'(mck),  64'((n / MH) % 2));
      check("lr",   64'(lr),   64'(c_lr));
      check("d",    64'(d),    64'(c_d));
      check("sRdy", 64'(srdy), 64'(!m_full));
      check("urun", 64'(urun), 64'(m_urun));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_n(input int target);
    int g;
    g = 0;
    do begin
      @(negedge clock);
      g++;
    end while (n < target && g < 200000);
    if (n != target) begin
      total++;
      $display("FAIL wait_n: reached edge %0d expected %0d", n, target);
    end
  endtask

  task automatic run_phase(input int cycles, input int pct);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock); #1;
      sval = ($urandom_range(99) < 32'(pct));
      for (int k = 0; k < LN; k++) begin
        ldata[k*DW +: DW] = DW'($urandom);
        rdata[k*DW +: DW] = DW'($urandom);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sck"},  64'(sck),  64'(0));
    check({tag, "_mck"},  64'(mck),  64'(0));
    check({tag, "_lr"},   64'(lr),   64'(1));
    check({tag, "_d"},    64'(d),    64'(0));
    check({tag, "_sRdy"}, 64'(srdy), 64'(1));
    check({tag, "_urun"}, 64'(urun), 64'(0));
  endtask

  logic [FB-1:0] w0, w1;
  int guard;

  initial begin
    repeat (3) @(negedge clock);
    check_reset_vals("rst");

    // Known frame: lane0 8001/7FFE, lane1 1234/ABCD
    ldata = {16'h1234, 16'h8001};
    rdata = {16'hABCD, 16'h7FFE};
    sval  = 1'b1;
    #1 rst_n = 1'b1;
    cmp_en = 1'b1;
    @(posedge clock); #1 sval = 1'b0;
    wait_n(1);  check("lit_srdy_after_accept", 64'(srdy), 64'(0));
    wait_n(3);  check("lit_sck_pre_rise", 64'(sck), 64'(0));
    wait_n(4);  check("lit_sck_rise", 64'(sck), 64'(1));
    wait_n(7);  check("lit_lr_pre_fall", 64'(lr), 64'(1));
    wait_n(8);
    check("lit_lr_fall", 64'(lr), 64'(0));
    check("lit_d_i2s_first", 64'(d), 64'(0));
    check("lit_srdy_after_xfer", 64'(srdy), 64'(1));
    w0 = '0; w1 = '0;
    for (int p = 1; p <= int'(FB); p++) begin
      wait_n(2 * SH * (p + 1));
      w0[FB - p] = d[0];
      w1[FB - p] = d[1];
    end
    check("lit_word_lane0", 64'(w0), 64'(32'h8001_7FFE));
    check("lit_word_lane1", 64'(w1), 64'(32'h1234_ABCD));
    check("lit_urun_frame1", 64'(urun), 64'(1));
    wait_n(2 * SH * (FB + 2) - 2 * SH + 1);
    check("lit_urun_one_clock", 64'(urun), 64'(0));

    // Randomised traffic: sparse, saturating, starved, then lj requested
    run_phase(6 * FRAME, 40);
    run_phase(4 * FRAME, 100);
    run_phase(2 * FRAME, 0);
    lj = 1'b1;
    run_phase(4 * FRAME, 60);
    lj = 1'b0;
    run_phase(2 * FRAME, 70);

    // Reset in the middle of a frame
    guard = 0;
    while ((n % FRAME) != FRAME / 2 && guard < 4 * FRAME) begin
      @(negedge clock);
      guard++;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    repeat (3) @(negedge clock);
    check("midrst_urun_hold", 64'(urun), 64'(0));
    check("midrst_lr_hold", 64'(lr), 64'(1));
    #1 rst_n = 1'b1;
    run_phase(3 * FRAME, 50);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
